// File: rtl/neuron_timestep_controller_if.sv
// Spike delivery, weight write, adder operand/result and status signals of the timestep controller.
interface neuron_timestep_controller_if #(parameter int SRC_W = 4);
  logic             timestep_start;
  logic             spike_valid;
  logic [SRC_W-1:0] spike_src;
  logic             spike_ready;
  logic             input_end;
  logic             wr_en;
  logic [SRC_W-1:0] wr_addr;
  logic [31:0]      wr_data;
  logic [31:0]      input_weight;
  logic [31:0]      decayed_potential;
  logic             adder_clear;
  logic             adder_set;
  logic [31:0]      final_potential;
  logic             spike_in;
  logic [31:0]      potential_out;
  logic             spike_out;
  logic             done;

  modport slave (
    input  timestep_start, spike_valid, spike_src, input_end, wr_en, wr_addr, wr_data,
           final_potential, spike_in,
    output spike_ready, input_weight, decayed_potential, adder_clear, adder_set,
           potential_out, spike_out, done
  );

  modport master (
    output timestep_start, spike_valid, spike_src, input_end, wr_en, wr_addr, wr_data,
           final_potential, spike_in,
    input  spike_ready, input_weight, decayed_potential, adder_clear, adder_set,
           potential_out, spike_out, done
  );
endinterface

// File: rtl/neuron_timestep_controller.sv
// Per-timestep sequencer: decay potential, accumulate spike weights, hand operands to the adder,
// capture its result. Float32 add/mul are round-to-nearest-even with denormals flushed to zero.
module neuron_timestep_controller #(
  parameter int          SRC_W = 4,
  parameter logic [31:0] DECAY = 32'h3F000000
) (
  input logic clk,
  input logic rst_n,
  neuron_timestep_controller_if.slave bus
);
  typedef enum logic [2:0] {INIT, IDLE, DECAY_ST, ACCUM, APPLY, CAPTURE} state_t;

  // m[26] hidden bit, m[26:3] mantissa, m[2] guard, m[1:0] round/sticky
  function automatic logic [31:0] pack_round(input logic sgn, input logic signed [9:0] exp_in,
                                             input logic [26:0] m);
    logic [24:0]       r;
    logic signed [9:0] e;
    e = exp_in;
    r = {1'b0, m[26:3]} + {24'd0, m[2] & (m[3] | m[1] | m[0])};
    if (r[24]) begin
      r = r >> 1;
      e = e + 10'sd1;
    end
    if (e <= 10'sd0)   return {sgn, 31'd0};
    if (e >= 10'sd255) return {sgn, 8'hFF, 23'd0};
    return {sgn, e[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [26:0]       m;
    logic              sgn;
    sgn = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sgn, 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m = {p[47:22], |p[21:0]};
      e = e + 10'sd1;
    end else begin
      m = {p[46:21], |p[20:0]};
    end
    return pack_round(sgn, e, m);
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [26:0]       mx, my;
    logic [27:0]       s;
    logic [7:0]        d;
    logic signed [9:0] e;
    logic              st;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {1'b1, x[22:0], 3'b000};
    my = {1'b1, y[22:0], 3'b000};
    if (d > 8'd26) begin
      st = 1'b1;
      my = '0;
    end else begin
      st = |(my & ((27'd1 << d) - 27'd1));
      my = my >> d;
    end
    my[0] = my[0] | st;
    e = $signed({2'b00, x[30:23]});
    if (x[31] == y[31]) begin
      s = {1'b0, mx} + {1'b0, my};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 10'sd1;
      end
    end else begin
      s = {1'b0, mx} - {1'b0, my};
      if (s == 28'd0) return 32'd0;
      // cancellation only shifts far when alignment was <= 1, so no sticky bits are lost
      for (int i = 0; i < 27; i++) begin
        if (!s[26]) begin
          s = s << 1;
          e = e - 10'sd1;
        end
      end
    end
    return pack_round(x[31], e, s[26:0]);
  endfunction

  state_t      state, state_nxt;
  logic [31:0] wram [2**SRC_W];
  logic [31:0] input_weight, decayed_potential, potential_out;
  logic        spike_out, done;
  logic        spike_ready, adder_clear, adder_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:     state_nxt = IDLE;
      IDLE:     if (bus.timestep_start) state_nxt = DECAY_ST;
      DECAY_ST: state_nxt = ACCUM;
      ACCUM:    if (bus.input_end) state_nxt = APPLY;
      APPLY:    state_nxt = CAPTURE;
      CAPTURE:  state_nxt = IDLE;
      default:  state_nxt = INIT;
    endcase
  end

  always_comb begin
    spike_ready = (state == ACCUM);
    adder_clear = (state == IDLE);
    adder_set   = (state == INIT);
  end

  // RAM is left out of reset; a same-cycle write is seen only by later reads
  always_ff @(posedge clk) begin
    if (bus.wr_en) wram[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      input_weight      <= '0;
      decayed_potential <= '0;
      potential_out     <= '0;
      spike_out         <= 1'b0;
      done              <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        DECAY_ST: begin
          decayed_potential <= fmul(potential_out, DECAY);
          input_weight      <= '0;
        end
        ACCUM:    if (bus.spike_valid) input_weight <= fadd(input_weight, wram[bus.spike_src]);
        CAPTURE: begin
          potential_out <= bus.final_potential;
          spike_out     <= bus.spike_in;
          done          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.spike_ready       = spike_ready;
  assign bus.adder_clear       = adder_clear;
  assign bus.adder_set         = adder_set;
  assign bus.input_weight      = input_weight;
  assign bus.decayed_potential = decayed_potential;
  assign bus.potential_out     = potential_out;
  assign bus.spike_out         = spike_out;
  assign bus.done              = done;
endmodule

// File: tb/tb_neuron_timestep_controller.sv
// Directed and randomized timesteps against a real-number model of the potential update.
module tb_neuron_timestep_controller;
  localparam int SRC_W = 4;
  localparam int NW    = 2**SRC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neuron_timestep_controller_if #(.SRC_W(SRC_W)) bus();
  neuron_timestep_controller #(.SRC_W(SRC_W), .DECAY(32'h3F000000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int  checks = 0;
  int  errors = 0;
  real wm [NW];
  real pot;
  bit  spk;
  int  sp_q [$];
  int  wr_k, wr_a, start_k, abort_k;
  logic [31:0] wr_d;

  function automatic real f2r(input logic [31:0] f);
    real v;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    for (int i = 0; i < e; i++)  v = v * 2.0;
    for (int i = 0; i < -e; i++) v = v / 2.0;
    return f[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    real         a;
    int          e;
    logic        s;
    logic [22:0] m;
    if (v == 0.0) return 32'd0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 127;
    for (int i = 0; i < 300 && a >= 2.0; i++) begin a = a / 2.0; e++; end
    for (int i = 0; i < 300 && a < 1.0; i++)  begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0));
    return {s, 8'(e), m};
  endfunction

  // adder stand-in: threshold 72.5, subtract on fire
  real add_s;
  always_comb begin
    add_s = f2r(bus.input_weight) + f2r(bus.decayed_potential);
    bus.spike_in = (add_s > 72.5);
    bus.final_potential = r2f((add_s > 72.5) ? add_s - 72.5 : add_s);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = SRC_W'(a); bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    wm[a] = f2r(d);
  endtask

  task automatic load_random();
    for (int a = 0; a < NW; a++) wr(a, r2f(real'($urandom_range(0, 23)) - 8.0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    tick();
    pot = 0.0; spk = 1'b0;
  endtask

  task automatic do_ts(input string tag);
    real dec, w, s;
    int  n, lat;
    bit  got;
    n = sp_q.size();
    chk({tag, "/idle_clear"}, 32'(bus.adder_clear), 32'd1);
    bus.timestep_start = 1'b1;
    tick();
    bus.timestep_start = 1'b0;
    chk({tag, "/decay_ready"}, 32'(bus.spike_ready), 32'd0);
    bus.spike_valid = 1'b1; bus.spike_src = SRC_W'($urandom);
    tick();
    bus.spike_valid = 1'b0;
    dec = pot * 0.5; w = 0.0;
    for (int k = 0; k < n; k++) begin
      chk({tag, "/accum_ready"}, 32'(bus.spike_ready), 32'd1);
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "/abort_set"}, 32'(bus.adder_set), 32'd1);
        chk({tag, "/abort_clear"}, 32'(bus.adder_clear), 32'd0);
        chk({tag, "/abort_pot"}, bus.potential_out, 32'd0);
        chk({tag, "/abort_iw"}, bus.input_weight, 32'd0);
        chk({tag, "/abort_spk"}, 32'(bus.spike_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
          chk({tag, "/abort_done"}, 32'(bus.done), 32'd0);
          tick();
        end
        rst_n = 1'b1;
        tick();
        chk({tag, "/abort_idle"}, 32'(bus.adder_clear), 32'd1);
        pot = 0.0; spk = 1'b0;
        return;
      end
      bus.spike_valid    = (sp_q[k] >= 0);
      bus.spike_src      = (sp_q[k] >= 0) ? SRC_W'(sp_q[k]) : SRC_W'($urandom);
      bus.input_end      = (k == n - 1);
      bus.timestep_start = (k == start_k);
      if (sp_q[k] >= 0) w = w + wm[sp_q[k]];
      if (k == wr_k) begin
        bus.wr_en = 1'b1; bus.wr_addr = SRC_W'(wr_a); bus.wr_data = wr_d;
        wm[wr_a] = f2r(wr_d);
      end
      tick();
      bus.spike_valid = 1'b0; bus.input_end = 1'b0; bus.timestep_start = 1'b0; bus.wr_en = 1'b0;
    end
    chk({tag, "/apply_iw"}, bus.input_weight, r2f(w));
    chk({tag, "/apply_dp"}, bus.decayed_potential, r2f(dec));
    chk({tag, "/apply_clear"}, 32'(bus.adder_clear), 32'd0);
    chk({tag, "/apply_set"}, 32'(bus.adder_set), 32'd0);
    chk({tag, "/apply_ready"}, 32'(bus.spike_ready), 32'd0);
    tick();
    chk({tag, "/capture_clear"}, 32'(bus.adder_clear), 32'd0);
    chk({tag, "/capture_done"}, 32'(bus.done), 32'd0);
    lat = n + 3; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      lat++;
      got = bus.done;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(n + 4));
    s = dec + w;
    spk = (s > 72.5);
    pot = spk ? s - 72.5 : s;
    chk({tag, "/pot"}, bus.potential_out, r2f(pot));
    chk({tag, "/spike"}, 32'(bus.spike_out), 32'(spk));
    tick();
    chk({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "/back_idle"}, 32'(bus.adder_clear), 32'd1);
    chk({tag, "/hold_pot"}, bus.potential_out, r2f(pot));
  endtask

  task automatic plain(input string tag);
    wr_k = -1; start_k = -1; abort_k = -1;
    do_ts(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.timestep_start = 1'b0; bus.spike_valid = 1'b0; bus.spike_src = '0; bus.input_end = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    pot = 0.0; spk = 1'b0;
    for (int a = 0; a < NW; a++) wm[a] = 0.0;

    repeat (2) tick();
    chk("rst/iw", bus.input_weight, 32'd0);
    chk("rst/dp", bus.decayed_potential, 32'd0);
    chk("rst/pot", bus.potential_out, 32'd0);
    chk("rst/spk", 32'(bus.spike_out), 32'd0);
    chk("rst/done", 32'(bus.done), 32'd0);
    chk("rst/set", 32'(bus.adder_set), 32'd1);
    chk("rst/clear", 32'(bus.adder_clear), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("init/set", 32'(bus.adder_set), 32'd1);
    tick();
    chk("idle/set", 32'(bus.adder_set), 32'd0);
    chk("idle/clear", 32'(bus.adder_clear), 32'd1);
    chk("idle/ready", 32'(bus.spike_ready), 32'd0);

    load_random();
    wr(3, 32'h42200000);

    sp_q = '{3};
    plain("single");
    chk("single/iw_k", bus.input_weight, 32'h42200000);
    chk("single/dp_k", bus.decayed_potential, 32'h00000000);
    chk("single/pot_k", bus.potential_out, 32'h42200000);
    chk("single/spk_k", 32'(bus.spike_out), 32'd0);

    sp_q = '{-1};
    plain("decay");
    chk("decay/dp_k", bus.decayed_potential, 32'h41A00000);
    chk("decay/iw_k", bus.input_weight, 32'h00000000);
    chk("decay/pot_k", bus.potential_out, 32'h41A00000);

    do_reset();
    sp_q = '{3, 3};
    plain("thresh");
    chk("thresh/iw_k", bus.input_weight, 32'h42A00000);
    chk("thresh/spk_k", 32'(bus.spike_out), 32'd1);
    chk("thresh/pot_k", bus.potential_out, 32'h40F00000);

    sp_q = '{3, 3};
    wr_k = 0; wr_a = 3; wr_d = 32'h3F800000; start_k = -1; abort_k = -1;
    do_ts("collide");
    chk("collide/iw_k", bus.input_weight, 32'h42240000);

    sp_q = '{3, -1, 3, -1};
    wr_k = -1; start_k = 1; abort_k = -1;
    do_ts("ign_start");

    sp_q = '{3, 3, 3};
    wr_k = -1; start_k = -1; abort_k = 1;
    do_ts("abort");

    for (int t = 0; t < 40; t++) begin
      int n;
      if (t % 10 == 0) load_random();
      n = $urandom_range(1, 4);
      sp_q = {};
      for (int k = 0; k < n; k++)
        sp_q.push_back(($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, NW - 1)));
      wr_k    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      wr_a    = $urandom_range(0, NW - 1);
      wr_d    = r2f(real'($urandom_range(0, 23)) - 8.0);
      start_k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      abort_k = (t % 10 == 9) ? int'($urandom_range(0, n - 1)) : -1;
      do_ts($sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
